keypad_scanner: RTL and testbench

- Drives the 4x4 matrix keypad column lines and samples its row lines.
- Debounces presses over whole scans and rejects multi-key (ghost) combinations.
- Emits one single-cycle strobe per confirmed press, carrying a 4-bit key code.
- Sits directly upstream of the key-code mapping stage; the code encoding below is that stage's input encoding.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/keypad_debouncer.sv | 112 +++++++++++
 rtl/keypad_scanner.sv | 110 +++++++++++
 tb/tb_keypad_scanner.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner and the downstream key-code mapping stage.
package keypad_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    HELD,
    RELEASE
  } db_state_e;

  // Key code layout: {row_idx, col_idx}; row 3 is the top row, col 3 the leftmost column.
  function automatic logic [KEY_W-1:0] pack_code(input logic [1:0] row_idx,
                                                 input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Scan-level debounce FSM: confirms a single key over DEBOUNCE_SCANS matching scans,
// then waits for DEBOUNCE_SCANS empty scans before accepting another press.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_done,
  input  logic             scan_single,
  input  logic [KEY_W-1:0] scan_code,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  db_state_e        state_q, state_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_full;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign cnt_full = (cnt_inc == CNT_W'(DEBOUNCE_SCANS));

  // Next-state and output logic; the FSM only moves on a completed scan.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (scan_done) begin
      case (state_q)
        IDLE: begin
          if (scan_single) begin
            state_d = CONFIRM;
            cand_d  = scan_code;
            cnt_d   = CNT_W'(1);
          end
        end
        CONFIRM: begin
          if (!scan_single) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (scan_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_full) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = HELD;
            end
          end else begin
            cand_d = scan_code;
            cnt_d  = CNT_W'(1);
          end
        end
        HELD: begin
          if (!scan_single) begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (scan_single) begin
            state_d = HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_full) begin
              key_held_d = 1'b0;
              state_d    = IDLE;
              cnt_d      = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives columns one at a time, synchronizes and samples rows,
// accumulates a per-scan hit count and hands the scan result to the debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       row_s1_q, row_s1_d;
  logic [3:0]       row_s2_q, row_s2_d;
  logic [1:0]       hit_cnt_q, hit_cnt_d;
  logic [KEY_W-1:0] hit_code_q, hit_code_d;

  logic             last_cycle;
  logic [2:0]       col_hits;
  logic [1:0]       col_row;
  logic [2:0]       merged_cnt;
  logic [1:0]       merged_sat;
  logic [KEY_W-1:0] merged_code;
  logic             scan_done;
  logic             scan_single;
  logic [KEY_W-1:0] scan_code;

  assign last_cycle = (div_q == DIV_W'(SCAN_DIV - 1));
  assign col        = ~(4'b0001 << col_idx_q);

  // Column timing, row synchronizer and the per-scan hit accumulator.
  // The hit count saturates at 2, which is all that ghost rejection needs to know.
  always_comb begin
    div_d       = div_q + DIV_W'(1);
    col_idx_d   = col_idx_q;
    row_s1_d    = row;
    row_s2_d    = row_s1_q;
    hit_cnt_d   = hit_cnt_q;
    hit_code_d  = hit_code_q;
    scan_done   = 1'b0;
    scan_single = 1'b0;
    scan_code   = hit_code_q;
    col_hits    = '0;
    col_row     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row_s2_q[i]) begin
        col_hits = col_hits + 3'd1;
        col_row  = i[1:0];
      end
    end
    merged_cnt  = {1'b0, hit_cnt_q} + col_hits;
    merged_sat  = (merged_cnt >= 3'd2) ? 2'd2 : merged_cnt[1:0];
    merged_code = (col_hits == 3'd1) ? pack_code(col_row, col_idx_q) : hit_code_q;
    if (last_cycle) begin
      div_d      = '0;
      col_idx_d  = col_idx_q + 2'd1;
      hit_cnt_d  = merged_sat;
      hit_code_d = merged_code;
      if (col_idx_q == 2'd3) begin
        scan_done   = 1'b1;
        scan_single = (merged_sat == 2'd1);
        scan_code   = merged_code;
        hit_cnt_d   = '0;
        hit_code_d  = '0;
      end
    end
  end

  // Scan-side registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      col_idx_q  <= '0;
      row_s1_q   <= '1;
      row_s2_q   <= '1;
      hit_cnt_q  <= '0;
      hit_code_q <= '0;
    end else begin
      div_q      <= div_d;
      col_idx_q  <= col_idx_d;
      row_s1_q   <= row_s1_d;
      row_s2_q   <= row_s2_d;
      hit_cnt_q  <= hit_cnt_d;
      hit_code_q <= hit_code_d;
    end
  end

  keypad_debouncer #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .scan_done  (scan_done),
    .scan_single(scan_single),
    .scan_code  (scan_code),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scans).
// Cycle numbers in comments count clock edges since the last reset edge.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  int vectors = 0;
  int miscompares = 0;
  int vcount = 0;
  int base = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Keypad matrix model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Count key_valid pulses.
  always @(negedge clk) if (key_valid === 1'b1) vcount <= vcount + 1;

  function automatic int kidx(input int r, input int c);
    return r * 4 + c;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset: two edges with reset high, then release at cycle 0.
    step(2);
    reset = 1'b0;
    check("rst_col", col, 4'b1110);
    check("rst_code", key_code, 4'b0000);
    check("rst_valid", {3'b0, key_valid}, 4'd0);
    check("rst_held", {3'b0, key_held}, 4'd0);
    step(4);  check("col_c1", col, 4'b1101);
    step(4);  check("col_c2", col, 4'b1011);
    step(4);  check("col_c3", col, 4'b0111);
    step(4);  check("col_wrap", col, 4'b1110);
    step(16); // cycle 32
    check("idle_held", {3'b0, key_held}, 4'd0);
    check("idle_pulses", 4'(vcount - base), 4'd0);

    // Key "1": confirmed after the 3rd scan_done (cycle 79), strobe at cycle 80.
    base = vcount;
    keys[kidx(3, 3)] = 1'b1;
    step(47); check("k1_early", {3'b0, key_valid}, 4'd0);
    step(1);
    check("k1_valid", {3'b0, key_valid}, 4'd1);
    check("k1_code", key_code, 4'b1111);
    check("k1_held", {3'b0, key_held}, 4'd1);
    step(1);  check("k1_one_cycle", {3'b0, key_valid}, 4'd0);
    step(15); // cycle 96
    keys = '0;
    step(32); check("k1_still_held", {3'b0, key_held}, 4'd1);
    step(16); check("k1_released", {3'b0, key_held}, 4'd0);
    check("k1_pulses", 4'(vcount - base), 4'd1);

    // Key "5" bouncing: 2 scans on, 1 off, 3 on.
    base = vcount;
    keys[kidx(2, 2)] = 1'b1;
    step(32);
    keys = '0;
    step(16);
    keys[kidx(2, 2)] = 1'b1;
    step(47);
    check("k5_early", {3'b0, key_valid}, 4'd0);
    check("k5_no_early_pulse", 4'(vcount - base), 4'd0);
    step(1);
    check("k5_valid", {3'b0, key_valid}, 4'd1);
    check("k5_code", key_code, 4'b1010);
    keys = '0;
    step(48);
    check("k5_released", {3'b0, key_held}, 4'd0);
    check("k5_pulses", 4'(vcount - base), 4'd1);

    // "A" and "2" together are ghost-rejected; releasing "2" lets "A" confirm.
    base = vcount;
    keys[kidx(3, 0)] = 1'b1;
    keys[kidx(3, 2)] = 1'b1;
    step(80);
    check("ghost_pulses", 4'(vcount - base), 4'd0);
    check("ghost_held", {3'b0, key_held}, 4'd0);
    keys[kidx(3, 2)] = 1'b0;
    step(47); check("ka_early", {3'b0, key_valid}, 4'd0);
    step(1);
    check("ka_valid", {3'b0, key_valid}, 4'd1);
    check("ka_code", key_code, 4'b1100);
    keys = '0;
    step(48);
    check("ka_released", {3'b0, key_held}, 4'd0);

    // "D" held, then slide to "#" with no gap: no new strobe until a release.
    base = vcount;
    keys[kidx(0, 0)] = 1'b1;
    step(48);
    check("kd_valid", {3'b0, key_valid}, 4'd1);
    check("kd_code", key_code, 4'b0000);
    keys = '0;
    keys[kidx(0, 1)] = 1'b1;
    step(48);
    check("slide_pulses", 4'(vcount - base), 4'd1);
    check("slide_held", {3'b0, key_held}, 4'd1);
    check("slide_code", key_code, 4'b0000);
    keys = '0;
    step(48);
    check("kd_released", {3'b0, key_held}, 4'd0);
    keys[kidx(0, 1)] = 1'b1;
    step(48);
    check("khash_valid", {3'b0, key_valid}, 4'd1);
    check("khash_code", key_code, 4'b0001);
    keys = '0;
    step(48);
    check("khash_released", {3'b0, key_held}, 4'd0);
    check("khash_pulses", 4'(vcount - base), 4'd2);

    // Reset after 2 matching scans of "9"; the key must re-confirm from scratch.
    keys[kidx(1, 1)] = 1'b1;
    step(32);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    base = vcount;
    check("mid_rst_col", col, 4'b1110);
    check("mid_rst_code", key_code, 4'b0000);
    step(47);
    check("k9_early", {3'b0, key_valid}, 4'd0);
    check("k9_no_early_pulse", 4'(vcount - base), 4'd0);
    step(1);
    check("k9_valid", {3'b0, key_valid}, 4'd1);
    check("k9_code", key_code, 4'b0101);
    keys = '0;
    step(48);
    check("k9_released", {3'b0, key_held}, 4'd0);
    check("k9_pulses", 4'(vcount - base), 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
